// File: rtl/lcd_pkg.sv
// Shared types and constants for the character-LCD write path.
// The arbiter state encoding, controller timing constants and the default watchdog limit.
package lcd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        HOLD  = 2'd2,
        DONE  = 2'd3
    } arbState_t;

    // Controller delay constants in 50 MHz clock cycles.
    localparam logic [19:0] wait50us = 20'd2500;
    localparam logic [19:0] wait1ms  = 20'd50000;
    localparam logic [19:0] wait5ms  = 20'd250000;
    localparam logic [19:0] wait20ms = 20'd1000000;

    localparam logic [19:0] TIMEOUT_DEFAULT = 20'd5000;

    function automatic logic [1:0] toOneHot(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/lcd_rr_picker.sv
// Combinational two-way winner selection for the LCD write arbiter.
// Define LCD_ARB_FIXED_PRIO_EN to make requester 0 win every tie instead of round-robin.
module lcd_rr_picker
    import lcd_pkg::*;
(
    input  logic [1:0] reqValid,
    input  logic       rrPtr,
    output logic [1:0] winner
);

    // A lone requester always wins; a tie is settled by rrPtr or by fixed priority.
    always_comb begin
        winner = 2'b00;
        case (reqValid)
            2'b01: winner = 2'b01;
            2'b10: winner = 2'b10;
            2'b11: begin
`ifdef LCD_ARB_FIXED_PRIO_EN
                winner = 2'b01;
`else
                winner = toOneHot(rrPtr);
`endif
            end
            default: winner = 2'b00;
        endcase
    end

endmodule

// File: rtl/lcd_write_arbiter.sv
// Shares the LCD controller write port between two requesters with a per-write watchdog.
// LCD_ARB_FIXED_PRIO_EN selects fixed priority (requester 0) instead of round-robin.
module lcd_write_arbiter
    import lcd_pkg::*;
#(
    parameter logic [19:0] TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  reqValid,
    input  logic [1:0]  reqAddrOrData,
    input  logic [15:0] reqData,
    output logic [1:0]  reqGrant,
    output logic        lcdValid,
    output logic        lcdAddrOrData,
    output logic [7:0]  lcdDataOut,
    input  logic        lcdBusLock,
    input  logic        errClear,
    output logic        timeoutErr,
    output logic        busy
);

    localparam logic [19:0] timeoutLast = TIMEOUT_CYCLES - 20'd1;

    arbState_t   state;
    arbState_t   nextState;
    logic [1:0]  pick;
    logic        winnerIdx;
    logic        rrPtr;
    logic [19:0] timer;
    logic        expire;
    logic        loadWrite;
    logic        timerAtLast;

    lcd_rr_picker uPicker (
        .reqValid (reqValid),
        .rrPtr    (rrPtr),
        .winner   (pick)
    );

    assign timerAtLast = (timer == timeoutLast);
    assign loadWrite   = (state == IDLE) && (nextState == ISSUE);

    // Expiry only counts when the handshake did not advance in the same cycle.
    always_comb begin
        nextState = state;
        expire    = 1'b0;
        case (state)
            IDLE: begin
                if (pick != 2'b00) nextState = ISSUE;
            end
            ISSUE: begin
                if (lcdBusLock) begin
                    nextState = HOLD;
                end else if (timerAtLast) begin
                    expire    = 1'b1;
                    nextState = DONE;
                end
            end
            HOLD: begin
                if (!lcdBusLock) begin
                    nextState = DONE;
                end else if (timerAtLast) begin
                    expire    = 1'b1;
                    nextState = DONE;
                end
            end
            DONE: nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // The captured write stays frozen until the next arbitration, so requesters may move on.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            winnerIdx     <= 1'b0;
            lcdAddrOrData <= 1'b0;
            lcdDataOut    <= 8'h00;
        end else if (loadWrite) begin
            winnerIdx     <= pick[1];
            lcdAddrOrData <= pick[1] ? reqAddrOrData[1] : reqAddrOrData[0];
            lcdDataOut    <= pick[1] ? reqData[15:8] : reqData[7:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rrPtr <= 1'b0;
        end else if (state == DONE) begin
`ifdef LCD_ARB_FIXED_PRIO_EN
            rrPtr <= 1'b0;
`else
            rrPtr <= ~winnerIdx;
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timer <= 20'd0;
        end else if (loadWrite) begin
            timer <= 20'd0;
        end else if (((state == ISSUE) || (state == HOLD)) && (timer != 20'hFFFFF)) begin
            timer <= timer + 20'd1;
        end
    end

    // A fresh timeout takes priority over a simultaneous clear request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timeoutErr <= 1'b0;
        end else if (expire) begin
            timeoutErr <= 1'b1;
        end else if (errClear) begin
            timeoutErr <= 1'b0;
        end
    end

    assign lcdValid = (state == ISSUE);
    assign reqGrant = (state == DONE) ? toOneHot(winnerIdx) : 2'b00;
    assign busy     = (state != IDLE);

endmodule

// File: tb/tb_lcd_write_arbiter.sv
// Directed self-checking bench for lcd_write_arbiter with a 16-cycle watchdog.
// Contention expectations follow LCD_ARB_FIXED_PRIO_EN when it is defined.
module tb_lcd_write_arbiter;

    logic        clk;
    logic        rst;
    logic [1:0]  reqValid;
    logic [1:0]  reqAddrOrData;
    logic [15:0] reqData;
    logic [1:0]  reqGrant;
    logic        lcdValid;
    logic        lcdAddrOrData;
    logic [7:0]  lcdDataOut;
    logic        lcdBusLock;
    logic        errClear;
    logic        timeoutErr;
    logic        busy;

    int numChecks = 0;
    int numFails  = 0;

    lcd_write_arbiter #(.TIMEOUT_CYCLES(20'd16)) dut (
        .clk           (clk),
        .rst           (rst),
        .reqValid      (reqValid),
        .reqAddrOrData (reqAddrOrData),
        .reqData       (reqData),
        .reqGrant      (reqGrant),
        .lcdValid      (lcdValid),
        .lcdAddrOrData (lcdAddrOrData),
        .lcdDataOut    (lcdDataOut),
        .lcdBusLock    (lcdBusLock),
        .errClear      (errClear),
        .timeoutErr    (timeoutErr),
        .busy          (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [1:0] valid, input logic [1:0] kind, input logic [15:0] data);
        reqValid      = valid;
        reqAddrOrData = kind;
        reqData       = data;
    endtask

    task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        numChecks++;
        assert (observed === expected) else begin
            numFails++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, " reqGrant"}, 16'(reqGrant), 16'h0);
        checkOutput({tag, " lcdValid"}, 16'(lcdValid), 16'h0);
        checkOutput({tag, " lcdAddrOrData"}, 16'(lcdAddrOrData), 16'h0);
        checkOutput({tag, " lcdDataOut"}, 16'(lcdDataOut), 16'h0);
        checkOutput({tag, " timeoutErr"}, 16'(timeoutErr), 16'h0);
        checkOutput({tag, " busy"}, 16'(busy), 16'h0);
    endtask

    initial begin
        logic       expIdx;
        logic [7:0] expByte;

        rst        = 1'b1;
        lcdBusLock = 1'b0;
        errClear   = 1'b0;
        applyStimulus(2'b00, 2'b00, 16'h0000);
        tick();
        tick();
        checkAllZero("reset");
        rst = 1'b0;
        tick();

        $display("[TB] single write from requester 0");
        applyStimulus(2'b01, 2'b00, 16'h0040);
        tick();
        checkOutput("single lcdValid", 16'(lcdValid), 16'h1);
        checkOutput("single lcdDataOut", 16'(lcdDataOut), 16'h40);
        checkOutput("single lcdAddrOrData", 16'(lcdAddrOrData), 16'h0);
        checkOutput("single busy", 16'(busy), 16'h1);
        tick();
        tick();
        lcdBusLock = 1'b1;
        tick();
        checkOutput("single hold lcdValid", 16'(lcdValid), 16'h0);
        for (int c = 0; c < 4; c++) begin
            checkOutput("single hold reqGrant", 16'(reqGrant), 16'h0);
            tick();
        end
        lcdBusLock = 1'b0;
        checkOutput("single pre-done reqGrant", 16'(reqGrant), 16'h0);
        tick();
        checkOutput("single reqGrant", 16'(reqGrant), 16'h1);
        checkOutput("single done lcdDataOut", 16'(lcdDataOut), 16'h40);
        applyStimulus(2'b00, 2'b00, 16'h0000);
        tick();
        checkOutput("single grant width", 16'(reqGrant), 16'h0);
        checkOutput("single idle busy", 16'(busy), 16'h0);

        $display("[TB] requester 1 data, reqData changed after capture");
        applyStimulus(2'b10, 2'b10, 16'h5500);
        tick();
        checkOutput("capture lcdDataOut", 16'(lcdDataOut), 16'h55);
        checkOutput("capture lcdAddrOrData", 16'(lcdAddrOrData), 16'h1);
        applyStimulus(2'b10, 2'b00, 16'hAAAA);
        lcdBusLock = 1'b1;
        tick();
        checkOutput("early lock lcdValid", 16'(lcdValid), 16'h0);
        checkOutput("stable lcdDataOut", 16'(lcdDataOut), 16'h55);
        checkOutput("stable lcdAddrOrData", 16'(lcdAddrOrData), 16'h1);
        lcdBusLock = 1'b0;
        tick();
        checkOutput("req1 reqGrant", 16'(reqGrant), 16'h2);
        checkOutput("req1 done lcdDataOut", 16'(lcdDataOut), 16'h55);
        applyStimulus(2'b00, 2'b00, 16'h0000);
        tick();

        $display("[TB] contention with both requesters held");
        applyStimulus(2'b11, 2'b11, 16'h4241);
        tick();
        for (int i = 0; i < 4; i++) begin
`ifdef LCD_ARB_FIXED_PRIO_EN
            expIdx = 1'b0;
`else
            expIdx = (i % 2) == 1;
`endif
            expByte = expIdx ? 8'h42 : 8'h41;
            checkOutput("contend lcdValid", 16'(lcdValid), 16'h1);
            checkOutput("contend lcdDataOut", 16'(lcdDataOut), 16'(expByte));
            checkOutput("contend lcdAddrOrData", 16'(lcdAddrOrData), 16'h1);
            lcdBusLock = 1'b1;
            tick();
            lcdBusLock = 1'b0;
            tick();
            checkOutput("contend reqGrant", 16'(reqGrant), expIdx ? 16'h2 : 16'h1);
            tick();
            checkOutput("contend idle busy", 16'(busy), 16'h0);
            if (i == 3) applyStimulus(2'b00, 2'b00, 16'h0000);
            tick();
        end

        $display("[TB] watchdog expiry in ISSUE");
        applyStimulus(2'b01, 2'b00, 16'h0010);
        tick();
        for (int c = 1; c < 16; c++) begin
            tick();
            checkOutput("timeout pending lcdValid", 16'(lcdValid), 16'h1);
            checkOutput("timeout pending timeoutErr", 16'(timeoutErr), 16'h0);
        end
        tick();
        checkOutput("timeout timeoutErr", 16'(timeoutErr), 16'h1);
        checkOutput("timeout reqGrant", 16'(reqGrant), 16'h1);
        checkOutput("timeout lcdValid", 16'(lcdValid), 16'h0);
        applyStimulus(2'b00, 2'b00, 16'h0000);
        tick();
        checkOutput("timeout sticky", 16'(timeoutErr), 16'h1);
        checkOutput("timeout idle busy", 16'(busy), 16'h0);
        errClear = 1'b1;
        tick();
        errClear = 1'b0;
        checkOutput("errClear clears", 16'(timeoutErr), 16'h0);

        $display("[TB] watchdog expiry in HOLD with simultaneous errClear");
        applyStimulus(2'b10, 2'b10, 16'h6600);
        tick();
        lcdBusLock = 1'b1;
        tick();
        for (int c = 2; c < 16; c++) tick();
        checkOutput("hold pending timeoutErr", 16'(timeoutErr), 16'h0);
        checkOutput("hold pending reqGrant", 16'(reqGrant), 16'h0);
        errClear = 1'b1;
        tick();
        errClear   = 1'b0;
        lcdBusLock = 1'b0;
        checkOutput("set beats clear", 16'(timeoutErr), 16'h1);
        checkOutput("hold timeout reqGrant", 16'(reqGrant), 16'h2);
        applyStimulus(2'b00, 2'b00, 16'h0000);
        tick();
        checkOutput("hold timeout idle", 16'(busy), 16'h0);
        errClear = 1'b1;
        tick();
        errClear = 1'b0;
        checkOutput("second errClear", 16'(timeoutErr), 16'h0);

        $display("[TB] reset while in HOLD");
        applyStimulus(2'b01, 2'b01, 16'h0077);
        tick();
        lcdBusLock = 1'b1;
        tick();
        checkOutput("pre-reset busy", 16'(busy), 16'h1);
        checkOutput("pre-reset lcdDataOut", 16'(lcdDataOut), 16'h77);
        rst = 1'b1;
        #1;
        checkAllZero("async reset");
        tick();
        checkOutput("reset no grant", 16'(reqGrant), 16'h0);
        rst        = 1'b0;
        lcdBusLock = 1'b0;
        tick();
        checkOutput("after reset lcdValid", 16'(lcdValid), 16'h1);
        checkOutput("after reset lcdDataOut", 16'(lcdDataOut), 16'h77);
        checkOutput("after reset lcdAddrOrData", 16'(lcdAddrOrData), 16'h1);
        lcdBusLock = 1'b1;
        tick();
        lcdBusLock = 1'b0;
        tick();
        checkOutput("after reset reqGrant", 16'(reqGrant), 16'h1);
        applyStimulus(2'b00, 2'b00, 16'h0000);
        tick();
        checkOutput("final busy", 16'(busy), 16'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
        $finish;
    end

endmodule
